// File: rtl/tap_pkg.sv
// Shared constants for the TAP data/instruction register block: state codes,
// opcodes, instruction width and the opcode-to-data-register decode.
package tap_pkg;

  localparam int IR_W = 4;

  typedef enum logic [3:0] {
    ST_EX2DR = 4'h0,
    ST_EX1DR = 4'h1,
    ST_SHDR  = 4'h2,
    ST_PAUDR = 4'h3,
    ST_SELIR = 4'h4,
    ST_UPDDR = 4'h5,
    ST_CAPDR = 4'h6,
    ST_SELDR = 4'h7,
    ST_EX2IR = 4'h8,
    ST_EX1IR = 4'h9,
    ST_SHIR  = 4'hA,
    ST_PAUIR = 4'hB,
    ST_RTI   = 4'hC,
    ST_UPDIR = 4'hD,
    ST_CAPIR = 4'hE,
    ST_TLR   = 4'hF
  } tap_state_e;

  localparam logic [IR_W-1:0] OP_IDCODE  = 4'b0001;
  localparam logic [IR_W-1:0] OP_USER    = 4'b0010;
  localparam logic [IR_W-1:0] OP_BYPASS  = 4'b1111;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

  // Unknown opcodes fall back to the 1-bit bypass register.
  function automatic dr_sel_e dr_select(input logic [IR_W-1:0] op);
    dr_sel_e sel;
    sel = DR_BYPASS;
    case (op)
      OP_IDCODE: sel = DR_IDCODE;
      OP_USER:   sel = DR_USER;
      default:   sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tap_shreg.sv
// Generic capture/shift data register: parallel load on capture, right shift
// with serial input into the MSB, LSB presented as serial output.
module tap_shreg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cap,
  input  logic         i_shift,
  input  logic [W-1:0] i_pin,
  input  logic         i_si,
  output logic         o_so,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sh;
  logic [W-1:0] w_shifted;

  generate
    if (W == 1) begin : g_one
      assign w_shifted = i_si;
    end else begin : g_multi
      assign w_shifted = {i_si, r_sh[W-1:1]};
    end
  endgenerate

  // Capture wins over shift; otherwise the register holds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh <= {W{1'b0}};
    end else if (i_cap) begin
      r_sh <= i_pin;
    end else if (i_shift) begin
      r_sh <= w_shifted;
    end else begin
      r_sh <= r_sh;
    end
  end

  assign o_so = r_sh[0];
  assign o_q  = r_sh;

endmodule

// File: rtl/tap_regs.sv
// TAP instruction and data registers (IDCODE, USER, BYPASS) driven by an
// externally supplied TAP controller state code.
module tap_regs
  import tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          USER_W     = 8
) (
  input  logic              GCLK_Pad,
  input  logic              TRST_Pad,
  input  logic              state_obs0_Pad,
  input  logic              state_obs1_Pad,
  input  logic              state_obs2_Pad,
  input  logic              state_obs3_Pad,
  input  logic              TDI_Pad,
  output logic              TDO_Pad,
  output logic [IR_W-1:0]   ir_q,
  input  logic [USER_W-1:0] user_in,
  output logic [USER_W-1:0] user_q,
  output logic              user_upd
);

  tap_state_e        w_state;
  dr_sel_e           w_sel;
  logic              w_cap_dr;
  logic              w_sh_dr;
  logic              w_id_so;
  logic [31:0]       w_id_q_unused;
  logic              w_user_so;
  logic [USER_W-1:0] w_user_q;
  logic [IR_W-1:0]   r_ir_sh;
  logic [IR_W-1:0]   r_ir_q;
  logic              r_bypass;
  logic [USER_W-1:0] r_user_q;
  logic              r_user_upd;
  logic              r_tdo_s;

  assign w_state  = tap_state_e'({state_obs3_Pad, state_obs2_Pad,
                                  state_obs1_Pad, state_obs0_Pad});
  assign w_sel    = dr_select(r_ir_q);
  assign w_cap_dr = (w_state == ST_CAPDR);
  assign w_sh_dr  = (w_state == ST_SHDR);

  tap_shreg #(.W(32)) u_idcode (
    .i_clk   (GCLK_Pad),
    .i_rst   (TRST_Pad),
    .i_cap   (w_cap_dr && (w_sel == DR_IDCODE)),
    .i_shift (w_sh_dr && (w_sel == DR_IDCODE)),
    .i_pin   (IDCODE_VAL),
    .i_si    (TDI_Pad),
    .o_so    (w_id_so),
    .o_q     (w_id_q_unused)
  );

  tap_shreg #(.W(USER_W)) u_user (
    .i_clk   (GCLK_Pad),
    .i_rst   (TRST_Pad),
    .i_cap   (w_cap_dr && (w_sel == DR_USER)),
    .i_shift (w_sh_dr && (w_sel == DR_USER)),
    .i_pin   (user_in),
    .i_si    (TDI_Pad),
    .o_so    (w_user_so),
    .o_q     (w_user_q)
  );

  // Instruction path; ir_q only moves at UpdIR or Test-Logic-Reset.
  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      r_ir_sh <= IR_CAPTURE;
      r_ir_q  <= OP_IDCODE;
    end else begin
      case (w_state)
        ST_CAPIR: r_ir_sh <= IR_CAPTURE;
        ST_SHIR:  r_ir_sh <= {TDI_Pad, r_ir_sh[IR_W-1:1]};
        ST_UPDIR: r_ir_q  <= r_ir_sh;
        ST_TLR:   r_ir_q  <= OP_IDCODE;
        default: begin
          r_ir_sh <= r_ir_sh;
          r_ir_q  <= r_ir_q;
        end
      endcase
    end
  end

  // Single-bit bypass register.
  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      r_bypass <= 1'b0;
    end else if (w_cap_dr && (w_sel == DR_BYPASS)) begin
      r_bypass <= 1'b0;
    end else if (w_sh_dr && (w_sel == DR_BYPASS)) begin
      r_bypass <= TDI_Pad;
    end else begin
      r_bypass <= r_bypass;
    end
  end

  // USER update register; the strobe lasts exactly one cycle after UpdDR.
  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      r_user_q   <= {USER_W{1'b0}};
      r_user_upd <= 1'b0;
    end else if ((w_state == ST_UPDDR) && (w_sel == DR_USER)) begin
      r_user_q   <= w_user_q;
      r_user_upd <= 1'b1;
    end else begin
      r_user_q   <= r_user_q;
      r_user_upd <= 1'b0;
    end
  end

  // TDO follows the live state code so the first shifted bit is visible at once.
  always_comb begin
    r_tdo_s = 1'b0;
    case (w_state)
      ST_SHIR: r_tdo_s = r_ir_sh[0];
      ST_SHDR: begin
        case (w_sel)
          DR_IDCODE: r_tdo_s = w_id_so;
          DR_USER:   r_tdo_s = w_user_so;
          default:   r_tdo_s = r_bypass;
        endcase
      end
      default: r_tdo_s = 1'b0;
    endcase
  end

  assign TDO_Pad  = r_tdo_s;
  assign ir_q     = r_ir_q;
  assign user_q   = r_user_q;
  assign user_upd = r_user_upd;

endmodule

// File: doc/tap_regs.md
TAP_REGS -- requirements
Module: tap_regs

Interface
REQ-001 Parameter IDCODE_VAL, default 32'h1000_0001, is the 32-bit device ID captured by IDCODE; bit 0 SHALL be 1.
REQ-002 Parameter USER_W, default 8, is the USER data register width (range 1..32).
REQ-003 Port GCLK_Pad, input, 1: the single clock; all state changes happen on its rising edge.
REQ-004 Port TRST_Pad, input, 1: reset; asynchronous, active-high.
REQ-005 Ports state_obs0_Pad..state_obs3_Pad, input, 1 each: TAP controller state code, bit 0..3, synchronous to GCLK_Pad.
REQ-006 Port TDI_Pad, input, 1: serial test data in.
REQ-007 Port TDO_Pad, output, 1: serial test data out.
REQ-008 Port ir_q, output, 4: active instruction.
REQ-009 Port user_in, input, USER_W: parallel value captured into the USER register.
REQ-010 Port user_q, output, USER_W: USER update register.
REQ-011 Port user_upd, output, 1: one-cycle pulse that marks a new user_q.

Function
REQ-012 Decode state code S={obs3,obs2,obs1,obs0} with the IEEE 1149.1 encoding:
- TLR=F, RTI=C
- SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
REQ-013 Each rising edge SHALL perform the action of the S value sampled at that edge.
REQ-014 Opcodes: IDCODE=4'b0001, USER=4'b0010, BYPASS=4'b1111; every other opcode SHALL select BYPASS.
REQ-015 IR path, 4-bit shift register ir_sh:
- CapIR: ir_sh <= 4'b0001
- ShIR: ir_sh <= {TDI, ir_sh[3:1]}
- UpdIR: ir_q <= ir_sh
- any other state: ir_sh holds
REQ-016 S=TLR: ir_q SHALL be forced to IDCODE at every edge.
REQ-017 DR path, selected by ir_q:
- BYPASS, 1-bit: CapDR loads 0; ShDR loads TDI.
- IDCODE, 32-bit: CapDR loads IDCODE_VAL; ShDR shifts right with TDI into the MSB.
- USER, USER_W-bit: CapDR loads user_in; ShDR shifts right with TDI into the MSB.
REQ-018 S=UpdDR with ir_q=USER: user_q <= USER shift value; user_upd SHALL be high for exactly the following cycle.
REQ-019 S=UpdDR with any other ir_q: user_q and user_upd SHALL not change.
REQ-020 TDO_Pad SHALL be combinational on S and the registers:
- S=ShIR: ir_sh[0]
- S=ShDR: bit 0 of the selected DR
- any other state: 0
REQ-021 ir_q changes only at UpdIR or TLR; a Shift-DR sequence in progress therefore always uses the instruction that was active at its CapDR.
REQ-022 Shift length is unbounded; bits shifted past the LSB are discarded.
REQ-023 Pause and Exit states SHALL hold all shift registers unchanged.
REQ-024 Undefined state codes cannot occur, because all 16 codes are defined.

Reset
REQ-025 While TRST_Pad=1, asynchronously:
- ir_q=IDCODE, ir_sh=4'b0001
- all DR shift registers = 0
- user_q=0, user_upd=0
REQ-026 TRST_Pad asserted mid-shift SHALL abort the shift; after release, operation resumes from the next sampled S with no residual pulse.

Structure
REQ-027 Shared package tap_pkg SHALL hold the 16 state-code constants, the 3 opcodes, and the IR width.
REQ-028 One sub-module, tap_shreg, SHALL be used for the IDCODE and USER registers:
- parameterised width
- capture/shift enables, parallel-in, serial-in, LSB-out

Verification
REQ-029 Pulse TRST_Pad -> ir_q=4'h1, user_q=0; then CapDR, 32×ShDR -> TDO sequence = IDCODE_VAL LSB-first (first bit 1).
REQ-030 CapIR, 4×ShIR with TDI=0,1,0,0, UpdIR -> TDO emits 1,0,0,0; ir_q=4'b0010.
REQ-031 ir_q=USER, user_in=8'hA5, CapDR, 8×ShDR with TDI=8'h3C LSB-first, UpdDR -> TDO emits A5 LSB-first; user_q=8'h3C; user_upd high for 1 cycle.
REQ-032 Load ir_q=4'b0111 (undefined), CapDR, 3×ShDR with TDI=1,0,1 -> TDO=0,1,0 (1-bit bypass delay).
REQ-033 S=TLR for one edge after ir_q=USER -> ir_q=IDCODE; a subsequent UpdDR does not pulse user_upd.
REQ-034 TRST_Pad asserted after 3 of 8 USER shifts -> all registers at reset values immediately; user_upd stays 0.
